// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator (optional frame counter: VGA_TIMING_FRAME_CNT_EN)
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int POS_W      = 10
) (
    input  logic             i_pixel_clock,
    input  logic             i_reset,
    input  logic             i_ce,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_video_on,
    output logic [POS_W-1:0] o_hpos,
    output logic [POS_W-1:0] o_vpos,
    output logic             o_line_start,
    output logic             o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]       o_frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [POS_W-1:0] H_LAST     = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_VIS      = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_VIS      = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] HS_FIRST   = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0] HS_LAST    = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_FIRST   = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0] VS_LAST    = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_ON      = (H_SYNC_POL != 0);
    localparam logic             VS_ON      = (V_SYNC_POL != 0);

    logic [POS_W-1:0] r_h_cnt;
    logic [POS_W-1:0] r_v_cnt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic [POS_W-1:0] r_hpos;
    logic [POS_W-1:0] r_vpos;
    logic             r_line_start;
    logic             r_frame_start;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_video;
    logic w_hs_act;
    logic w_vs_act;
    logic w_line_first;
    logic w_frame_first;

    // Decode the current (pre-increment) position; every output registers this.
    assign w_h_wrap      = (r_h_cnt == H_LAST);
    assign w_v_wrap      = (r_v_cnt == V_LAST);
    assign w_video       = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hs_act      = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign w_vs_act      = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
    assign w_line_first  = (r_h_cnt == '0);
    assign w_frame_first = w_line_first && (r_v_cnt == '0);

    always_ff @(posedge i_pixel_clock) begin
        if (i_reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_video_on    <= 1'b0;
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (i_ce) begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
            end
            r_hsync       <= w_hs_act ? HS_ON : ~HS_ON;
            r_vsync       <= w_vs_act ? VS_ON : ~VS_ON;
            r_video_on    <= w_video;
            r_hpos        <= r_h_cnt;
            r_vpos        <= r_v_cnt;
            r_line_start  <= w_line_first;
            r_frame_start <= w_frame_first;
        end else begin
            // Strobes mark enabled edges only; level outputs hold.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_video_on    = r_video_on;
    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge i_pixel_clock) begin
        if (i_reset) begin
            r_frame_count <= 8'd0;
        end else if (i_ce && w_frame_first) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign o_frame_count = r_frame_count;
`endif

endmodule
